// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, valid/ready on both sides.
// Round keys come from a combinational expansion of the registered cipher key.
module aes_decrypt_iter #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_text,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_text,
    output logic         busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_iter supports NR = 10 (AES-128) only");
    end

    // Entry x lives at bits [8*(255-x) +: 8], so {~x, 3'b000} is its offset.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Byte (row r, column c) sits at index 4c+r; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [0:1407] key_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1407] o;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[127 - 32*i -: 32];
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = {sbox(t[23:16]) ^ rcon, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) begin
            o[32*i +: 32] = w[i];
        end
        return o;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } state_e;

    state_e        r_fsm;
    state_e        w_fsm_nxt;
    logic [127:0]  r_state;
    logic [127:0]  w_state_nxt;
    logic [127:0]  r_key;
    logic [127:0]  w_key_nxt;
    logic [127:0]  r_pt;
    logic [127:0]  w_pt_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [127:0]  w_exp_key;
    logic [0:1407] w_sched;
    logic [127:0]  w_rk;
    logic [127:0]  w_ark;
    logic [127:0]  w_imc;

    // One shared expansion: in IDLE it sees the incoming key to form round key 10,
    // afterwards the registered key supplies keys 9..0.
    assign w_exp_key = (r_fsm == StIdle) ? key : r_key;
    assign w_sched   = key_expand(w_exp_key);
    assign w_rk      = (r_fsm == StIdle) ? w_sched[1280 +: 128] : w_sched[{r_cnt, 7'b0} +: 128];
    assign w_ark     = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk;
    assign w_imc     = inv_mix_columns(w_ark);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= StIdle;
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_pt    <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pt    <= w_pt_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_pt_nxt    = r_pt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        plain_text  = r_pt;
        unique case (r_fsm)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = cipher_text ^ w_rk;
                    w_key_nxt   = key;
                    w_cnt_nxt   = 4'd9;
                    w_fsm_nxt   = StRound;
                end
            end
            StRound: begin
                busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_state_nxt = w_imc;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_pt_nxt  = w_ark;
                    w_fsm_nxt = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_nxt = StIdle;
                end
            end
            default: begin
                w_fsm_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, handshake timing, reset abort and a
// random round trip against a byte-level AES encryption model.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_text;
    logic [0:127] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_text;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cipher_text(cipher_text),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plain_text (plain_text),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   t0;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127 - 8*i -: 8];
            s[i] = p[127 - 8*i -: 8] ^ w[i];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                t0     = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc     = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            end
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]     = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c + 1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c + 2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c + 3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c + r] = t[4*c + r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*rnd + i];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // Offer one block, check accept, latency and result, then release after `stall` cycles.
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] exp_pt, input int stall);
        int lat;
        int w;
        in_valid    = 1'b1;
        key         = k;
        cipher_text = ct;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, " ready"}, 128'(in_ready), 128'd1);
        tick();
        in_valid    = 1'b0;
        key         = rand128();
        cipher_text = rand128();
        check({tag, " busy/in_ready"}, {126'd0, busy, in_ready}, 128'b10);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'd10);
        check({tag, " plain"}, plain_text, exp_pt);
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " release"}, {126'd0, out_valid, in_ready}, 128'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int           accs [$];
        logic [127:0] res [$];
        logic         acc;
        logic         seen;
        logic [127:0] pt;

        build_sbox();
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        key         = '0;
        cipher_text = '0;
        repeat (3) tick();
        check("reset ctrl", {125'd0, in_ready, out_valid, busy}, 128'b100);
        check("reset plain", plain_text, 128'd0);
        rst = 1'b0;
        tick();

        run_block("fips c1", K1, C1, P1, 0);
        run_block("fips b", K2, C2, P2, 0);

        // Backpressure: result must hold while inputs churn.
        in_valid    = 1'b1;
        key         = K2;
        cipher_text = C2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("bp first", plain_text, P2);
        for (int i = 0; i < 20; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            cipher_text = rand128();
            key         = rand128();
            tick();
            check("bp hold ctrl", {125'd0, out_valid, in_ready, busy}, 128'b100);
            check("bp hold plain", plain_text, P2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release", {126'd0, out_valid, in_ready}, 128'b01);

        // Back-to-back: IDLE + 10 ROUND + DONE puts accepts 12 edges apart.
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        key         = K1;
        cipher_text = C1;
        for (int e = 0; e < 60 && res.size() < 2; e++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                accs.push_back(e);
                key         = K2;
                cipher_text = C2;
                if (accs.size() == 2) in_valid = 1'b0;
            end
            if (out_valid) res.push_back(plain_text);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("b2b accepts", 128'(accs.size()), 128'd2);
        check("b2b spacing", 128'(accs.size() == 2 ? accs[1] - accs[0] : -1), 128'd12);
        check("b2b result1", res.size() > 0 ? res[0] : '0, P1);
        check("b2b result2", res.size() > 1 ? res[1] : '0, P2);

        // Reset in flight: nothing may come out, outputs return to reset values.
        in_valid    = 1'b1;
        key         = K1;
        cipher_text = C1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst ctrl", {125'd0, out_valid, in_ready, busy}, 128'b010);
        check("midrst plain", plain_text, 128'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= out_valid;
        end
        check("midrst no output", 128'(seen), 128'd0);
        run_block("after rst", K1, C1, P1, 0);

        // Round trip through the model encryption.
        for (int i = 0; i < 100; i++) begin
            logic [127:0] rk;
            rk = rand128();
            pt = rand128();
            run_block("round trip", rk, model_encrypt(rk, pt), pt, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
